flag_buf4: RTL and testbench
============================

FLAG_BUF4 -- requirements
Module: flag_buf4

Interface
REQ-001 Parameter CNT_W, default 4, width of the saturating overflow-event counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU slice presents op/result/flags this cycle.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 in_op  input  3  ALU opcode (3'b110 add, 3'b111 sub, others logic/shift).
REQ-007 in_result  input  4  ALU result.
REQ-008 in_c, in_n, in_z, in_v  input  1 each  flags from the 4-bit flag calculator.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream consumes head entry this cycle.
REQ-011 out_op  output  3; out_result  output  4; out_flags  output  4 ({c,n,z,v}) of head entry.
REQ-012 cond  input  4  condition-code select evaluated against head flags.
REQ-013 cond_true  output  1  selected condition holds for head entry.
REQ-014 clr_cnt  input  1  synchronous clear of ovf_cnt.
REQ-015 ovf_cnt  output  CNT_W  count of accepted add/sub entries with v=1.

Function
REQ-016 Storage SHALL be a 2-entry FIFO of {op[2:0], result[3:0], c, n, z, v} (11 bits), with occupancy count 0..2.
REQ-017 Push SHALL occur on an edge where in_valid && in_ready; pop on an edge where out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != 2), derived from registered state only (no combinational path from out_ready).
REQ-019 out_valid SHALL equal (count != 0); out_op/out_result/out_flags SHALL show the head entry, and SHALL be zero when count = 0.
REQ-020 Latency: an entry pushed into an empty buffer SHALL appear on out_* in the cycle after the push edge (1 cycle).
REQ-021 Simultaneous push and pop with count = 1 SHALL leave count = 1, with the new entry becoming head; order SHALL be preserved (FIFO).
REQ-022 With count = 2, in_valid SHALL be ignored; a pop that cycle leaves count = 1 and in_ready rises next cycle.
REQ-023 Pop with count = 0 and push with count = 2 SHALL have no effect.
REQ-024 Read/write pointers SHALL be 1 bit and wrap 1->0.
REQ-025 cond decode: 0 EQ z; 1 NE !z; 2 CS c; 3 CC !c; 4 MI n; 5 PL !n; 6 VS v; 7 VC !v; 8 HI c&!z; 9 LS !c|z; A GE n==v; B LT n!=v; C GT !z&(n==v); D LE z|(n!=v); E AL 1; F NV 0.
REQ-026 cond_true SHALL be combinational from cond and head flags, and forced 0 when out_valid = 0.
REQ-027 ovf_cnt SHALL increment by 1 on each push where in_op[2:1] = 2'b11 and in_v = 1, saturating at 2^CNT_W-1.
REQ-028 clr_cnt SHALL set ovf_cnt to 0 on the next edge; clr_cnt wins over a same-cycle increment.

Reset
REQ-029 reset asserted SHALL immediately force count = 0, pointers = 0, ovf_cnt = 0, hence in_ready = 1, out_valid = 0, out_* = 0, cond_true = 0.
REQ-030 Reset mid-operation SHALL discard all buffered entries; no push/pop occurs on an edge while reset is high.
REQ-031 Storage contents need not be reset, but SHALL never be visible while out_valid = 0.

Configuration
REQ-032 Macro FLAG_BUF4_COND_EVAL_EN defined: cond decode per REQ-025/026 is compiled in.
REQ-033 Macro undefined: cond is ignored, cond_true SHALL be tied 0, and no decode logic is built; all other behaviour is unchanged.

Verification
REQ-034 Reset, then push op=110 result=4'h0 c=1 n=0 z=1 v=0 with out_ready=0 -> next cycle out_valid=1, out_result=0, out_flags=4'b1010, in_ready=1.
REQ-035 Push 3 entries back-to-back with out_ready=0 -> 3rd refused, in_ready=0 after 2nd push; then out_ready=1 -> entries 1,2 emerge in order, 3rd accepted once in_ready=1.
REQ-036 count=1, push and pop same edge -> count stays 1, out_* shows the newly pushed entry next cycle.
REQ-037 (COND_EVAL_EN) head flags n=1 v=0 z=0: cond=B -> cond_true=1; cond=A -> 0; cond=D -> 1; out_valid=0 -> 0 for all cond.
REQ-038 CNT_W=2: push 5 entries op=111 v=1 -> ovf_cnt saturates at 3; op=101 v=1 push -> unchanged; clr_cnt together with op=110 v=1 push -> ovf_cnt=0.
REQ-039 Assert reset asynchronously between edges with count=2 -> out_valid=0, in_ready=1, ovf_cnt=0 immediately, before next clk edge.

Source files
------------

// File: rtl/flag_buf4_if.sv
// Handshake bundle for flag_buf4: upstream ALU-slice push side and downstream pop side.
// The slave modport is the buffer; the master modport is whatever drives and consumes it.
interface flag_buf4_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_result;
  logic       in_c;
  logic       in_n;
  logic       in_z;
  logic       in_v;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op;
  logic [3:0] out_result;
  logic [3:0] out_flags;

  modport slave (
    input  in_valid, in_op, in_result, in_c, in_n, in_z, in_v, out_ready,
    output in_ready, out_valid, out_op, out_result, out_flags
  );

  modport master (
    output in_valid, in_op, in_result, in_c, in_n, in_z, in_v, out_ready,
    input  in_ready, out_valid, out_op, out_result, out_flags
  );
endinterface

// File: rtl/flag_buf4.sv
// Two-entry FIFO of ALU op/result/flags with a saturating overflow-event counter.
// Define FLAG_BUF4_COND_EVAL_EN to build the condition-code evaluator on the head entry.
module flag_buf4 #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  flag_buf4_if.slave       bus,
  input  logic [3:0]       cond,
  output logic             cond_true,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] result;
    logic       c;
    logic       n;
    logic       z;
    logic       v;
  } entry_t;

  entry_t     mem [2];
  entry_t     head;
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;
  logic       ovf_event;

  // Handshakes depend only on registered occupancy, so out_ready never reaches in_ready.
  assign push = bus.in_valid && (count != 2'd2);
  assign pop  = bus.out_ready && (count != 2'd0);
  assign ovf_event = push && (bus.in_op[2:1] == 2'b11) && bus.in_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; it is only ever observed through the count-gated outputs.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{op: bus.in_op, result: bus.in_result,
                       c: bus.in_c, n: bus.in_n, z: bus.in_z, v: bus.in_v};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (ovf_event && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.in_ready   = (count != 2'd2);
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_op     = bus.out_valid ? head.op : 3'd0;
  assign bus.out_result = bus.out_valid ? head.result : 4'd0;
  assign bus.out_flags  = bus.out_valid ? {head.c, head.n, head.z, head.v} : 4'd0;

`ifdef FLAG_BUF4_COND_EVAL_EN
  always_comb begin
    cond_true = 1'b0;
    if (bus.out_valid) begin
      case (cond)
        4'h0: cond_true = head.z;
        4'h1: cond_true = !head.z;
        4'h2: cond_true = head.c;
        4'h3: cond_true = !head.c;
        4'h4: cond_true = head.n;
        4'h5: cond_true = !head.n;
        4'h6: cond_true = head.v;
        4'h7: cond_true = !head.v;
        4'h8: cond_true = head.c && !head.z;
        4'h9: cond_true = !head.c || head.z;
        4'hA: cond_true = (head.n == head.v);
        4'hB: cond_true = (head.n != head.v);
        4'hC: cond_true = !head.z && (head.n == head.v);
        4'hD: cond_true = head.z || (head.n != head.v);
        4'hE: cond_true = 1'b1;
        default: cond_true = 1'b0;
      endcase
    end
  end
`else
  logic cond_unused;
  assign cond_unused = ^cond;
  assign cond_true   = 1'b0;
`endif

endmodule

// File: tb/tb_flag_buf4.sv
// Self-checking bench for flag_buf4 (CNT_W=2): vector table plus scoreboard queue,
// with hand sequences for async reset and condition-code corners.
module tb_flag_buf4;

  localparam int CNT_W = 2;

  typedef struct {
    logic       iv;
    logic [2:0] op;
    logic [3:0] res;
    logic [3:0] fl;
    logic       ordy;
    logic [3:0] cond;
    logic       clr;
    int         exp_cnt;
    int         exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] res;
    logic [3:0] fl;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       cond;
  logic             cond_true;
  logic             clr_cnt;
  logic [CNT_W-1:0] ovf_cnt;

  flag_buf4_if bus();

  flag_buf4 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cond      (cond),
    .cond_true (cond_true),
    .clr_cnt   (clr_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_passed = 0;
  ent_t sbq[$];
  vec_t vecs[17];

  function automatic vec_t mk(logic iv, logic [2:0] op, logic [3:0] res, logic [3:0] fl,
                              logic ordy, logic [3:0] cnd, logic clr, int ec, int eo);
    vec_t v;
    v.iv = iv; v.op = op; v.res = res; v.fl = fl; v.ordy = ordy;
    v.cond = cnd; v.clr = clr; v.exp_cnt = ec; v.exp_ovf = eo;
    return v;
  endfunction

  // Reference condition decode on {c,n,z,v}; always false when no head or evaluator absent.
  function automatic logic exp_cond(logic valid, logic [3:0] cnd, logic [3:0] f);
    logic c, n, z, v, r;
    c = f[3]; n = f[2]; z = f[1]; v = f[0];
    r = 1'b0;
`ifdef FLAG_BUF4_COND_EVAL_EN
    case (cnd)
      4'h0: r = z;          4'h1: r = !z;
      4'h2: r = c;          4'h3: r = !c;
      4'h4: r = n;          4'h5: r = !n;
      4'h6: r = v;          4'h7: r = !v;
      4'h8: r = c & !z;     4'h9: r = !c | z;
      4'hA: r = (n == v);   4'hB: r = (n != v);
      4'hC: r = !z & (n == v);
      4'hD: r = z | (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
`endif
    return valid ? r : 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    else
      n_passed++;
  endtask

  task automatic drive(input logic iv, input logic [2:0] op, input logic [3:0] res,
                       input logic [3:0] fl, input logic ordy);
    bus.in_valid  = iv;
    bus.in_op     = op;
    bus.in_result = res;
    bus.in_c      = fl[3];
    bus.in_n      = fl[2];
    bus.in_z      = fl[1];
    bus.in_v      = fl[0];
    bus.out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input int exp_cnt, input int exp_ovf);
    ent_t h;
    logic hv;
    hv = (sbq.size() != 0);
    h  = hv ? sbq[0] : '0;
    check({tag, " in_ready"},   bus.in_ready,   exp_cnt != 2);
    check({tag, " out_valid"},  bus.out_valid,  exp_cnt != 0);
    check({tag, " out_op"},     bus.out_op,     h.op);
    check({tag, " out_result"}, bus.out_result, h.res);
    check({tag, " out_flags"},  bus.out_flags,  h.fl);
    check({tag, " cond_true"},  cond_true,      exp_cond(hv, cond, h.fl));
    check({tag, " ovf_cnt"},    ovf_cnt,        exp_ovf);
  endtask

  // Drive one cycle of stimulus, update the scoreboard at the edge, check 1ns later.
  task automatic applyStimulus(input string tag, input vec_t v);
    logic acc, popq;
    drive(v.iv, v.op, v.res, v.fl, v.ordy);
    cond    = v.cond;
    clr_cnt = v.clr;
    acc  = v.iv && (sbq.size() != 2);
    popq = v.ordy && (sbq.size() != 0);
    @(posedge clk);
    if (popq) void'(sbq.pop_front());
    if (acc) sbq.push_back('{op: v.op, res: v.res, fl: v.fl});
    #1;
    checkOutput(tag, v.exp_cnt, v.exp_ovf);
  endtask

  initial begin
    //               iv    op      res    fl(cnvz) ordy  cond  clr  cnt ovf
    vecs[0]  = mk(1'b1, 3'b110, 4'h0, 4'b1010, 1'b0, 4'h0, 1'b0, 1, 0);
    vecs[1]  = mk(1'b1, 3'b111, 4'h5, 4'b0001, 1'b0, 4'h1, 1'b0, 2, 1);
    vecs[2]  = mk(1'b1, 3'b111, 4'h6, 4'b0101, 1'b0, 4'h2, 1'b0, 2, 1);
    vecs[3]  = mk(1'b0, 3'b000, 4'h0, 4'b0000, 1'b1, 4'h3, 1'b0, 1, 1);
    vecs[4]  = mk(1'b1, 3'b111, 4'h6, 4'b0101, 1'b1, 4'h4, 1'b0, 1, 2);
    vecs[5]  = mk(1'b1, 3'b101, 4'h7, 4'b0001, 1'b0, 4'h5, 1'b0, 2, 2);
    vecs[6]  = mk(1'b1, 3'b110, 4'h8, 4'b1001, 1'b0, 4'h6, 1'b0, 2, 2);
    vecs[7]  = mk(1'b0, 3'b000, 4'h0, 4'b0000, 1'b1, 4'h7, 1'b0, 1, 2);
    vecs[8]  = mk(1'b0, 3'b000, 4'h0, 4'b0000, 1'b1, 4'h8, 1'b0, 0, 2);
    vecs[9]  = mk(1'b0, 3'b000, 4'h0, 4'b0000, 1'b1, 4'hE, 1'b0, 0, 2);
    vecs[10] = mk(1'b1, 3'b111, 4'h9, 4'b0001, 1'b1, 4'h9, 1'b0, 1, 3);
    vecs[11] = mk(1'b1, 3'b110, 4'hA, 4'b0001, 1'b1, 4'hA, 1'b0, 1, 3);
    vecs[12] = mk(1'b1, 3'b111, 4'hB, 4'b0001, 1'b0, 4'hB, 1'b0, 2, 3);
    vecs[13] = mk(1'b0, 3'b000, 4'h0, 4'b0000, 1'b1, 4'hC, 1'b0, 1, 3);
    vecs[14] = mk(1'b1, 3'b110, 4'hC, 4'b0001, 1'b0, 4'hD, 1'b1, 2, 0);
    vecs[15] = mk(1'b1, 3'b111, 4'hD, 4'b1101, 1'b1, 4'hE, 1'b0, 1, 0);
    vecs[16] = mk(1'b1, 3'b111, 4'hD, 4'b1101, 1'b0, 4'hF, 1'b0, 2, 1);

    reset   = 1'b1;
    cond    = 4'hE;
    clr_cnt = 1'b0;
    drive(1'b1, 3'b111, 4'hF, 4'b1111, 1'b1);
    #1;
    checkOutput("reset", 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 3'b000, 4'h0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++)
      applyStimulus($sformatf("v%0d", i), vecs[i]);

    // Asynchronous reset between edges with the buffer full.
    drive(1'b0, 3'b000, 4'h0, 4'b0000, 1'b0);
    cond = 4'hE;
    #3;
    reset = 1'b1;
    #1;
    sbq.delete();
    checkOutput("async_reset", 0, 0);
    drive(1'b1, 3'b111, 4'h3, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("reset_no_push", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 3'b000, 4'h0, 4'b0000, 1'b0);
    #1;
    checkOutput("reset_release", 0, 0);

    // Head with n=1 v=0 z=0: signed-compare conditions.
    applyStimulus("cond_push", mk(1'b1, 3'b010, 4'h3, 4'b0100, 1'b0, 4'hB, 1'b0, 1, 0));
    drive(1'b0, 3'b000, 4'h0, 4'b0000, 1'b0);
    cond = 4'hB; #1;
    check("cond_LT", cond_true, exp_cond(1'b1, 4'hB, 4'b0100));
    cond = 4'hA; #1;
    check("cond_GE", cond_true, exp_cond(1'b1, 4'hA, 4'b0100));
    cond = 4'hD; #1;
    check("cond_LE", cond_true, exp_cond(1'b1, 4'hD, 4'b0100));
    applyStimulus("cond_pop", mk(1'b0, 3'b000, 4'h0, 4'b0000, 1'b1, 4'hE, 1'b0, 0, 0));
    bus.out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      check($sformatf("cond_empty_%0h", c), cond_true, 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
